// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: serialises a captured word as start, data (LSB first),
// optional parity and stop, one bit per clk cycle. Outputs are registered.
module uart_tx_ctrl #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Data_valid,
  input  logic [Width-1:0] in_data,
  input  logic             parity_enable,
  input  logic             parity_type,
  output logic             tx_out,
  output logic             busy,
  output logic [2:0]       state_o
);

  localparam int CW = $clog2(Width);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Handshake: Data_valid is a strobe with no ready output; it is accepted only at an
  // edge where the block is in IDLE or STOP, and silently dropped in any other state.

  state_t           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [Width-1:0] data_q, data_d;
  logic             par_en_q, par_en_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_inc;
  logic             last_bit;

  assign cnt_inc  = bit_cnt_q + CW'(1);
  assign last_bit = (bit_cnt_q == CW'(Width - 1));

  // Next-state and next-output logic; tx/busy are computed for the state being entered.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_d     = par_q;
    tx_d      = 1'b1;
    busy_d    = 1'b0;
    case (state_q)
      IDLE, STOP: begin
        if (Data_valid) begin
          state_d  = START;
          data_d   = in_data;
          par_en_d = parity_enable;
          par_d    = (^in_data) ^ parity_type;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d   = DATA;
        bit_cnt_d = '0;
        tx_d      = data_q[0];
        busy_d    = 1'b1;
      end
      DATA: begin
        if (last_bit) begin
          bit_cnt_d = '0;
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_q;
            busy_d  = 1'b1;
          end else begin
            state_d = STOP;
          end
        end else begin
          bit_cnt_d = cnt_inc;
          tx_d      = data_q[cnt_inc];
          busy_d    = 1'b1;
        end
      end
      PARITY: begin
        state_d = STOP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_out  = tx_q;
  assign busy    = busy_q;
  assign state_o = state_q;

endmodule
